// File: rtl/si5324_pkg.sv
`default_nettype none
// ============================================================================
// Module      : si5324_pkg
// Description : Shared types and constants for the SI5324 I2C register writer
// Revision    : 1.0 - initial release
// ============================================================================
package si5324_pkg;

  // Top-level transaction states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    ACK   = 3'd3,
    STOP  = 3'd4
  } state_t;

  localparam int BYTES_PER_WRITE = 3;  // addr+W, register, data
  localparam int BITS_PER_BYTE   = 8;

  // System clocks per quarter of an SCL period
  function automatic int unsigned qtr_cycles(input int unsigned clk_freq,
                                             input int unsigned i2c_freq);
    return clk_freq / (32'd4 * i2c_freq);
  endfunction

endpackage
`default_nettype wire

// File: rtl/si5324_i2c_writer_qtr_tick.sv
`default_nettype none
// ============================================================================
// Module      : i2c_qtr_tick
// Description : Quarter-bit timebase. Pulses tick on the last cycle of each
//               quarter and tracks which quarter of the bit is active.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_qtr_tick #(
  parameter int unsigned QTR = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  output logic       tick,
  output logic [1:0] phase
);

  localparam int CW = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(QTR - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CNT_MAX);

  // Quarter counter and bit phase; clr realigns both to the start of a bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 2'd0;
    end else if (clr) begin
      cnt   <= '0;
      phase <= 2'd0;
    end else if (en) begin
      if (cnt == CNT_MAX) begin
        cnt   <= '0;
        phase <= phase + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/si5324_i2c_writer.sv
`default_nettype none
// ============================================================================
// Module      : si5324_i2c_writer
// Description : Single-register I2C write master (START, addr+W, reg, data,
//               STOP) with ACK checking, fed by a valid/ready request port.
// Revision    : 1.0 - initial release
// ============================================================================
module si5324_i2c_writer
  import si5324_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 200_000_000,
  parameter int unsigned I2C_FREQ = 100_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl,
  inout  wire        sda
);

  localparam int unsigned QTR       = qtr_cycles(CLK_FREQ, I2C_FREQ);
  localparam logic [1:0]  LAST_BYTE = 2'(BYTES_PER_WRITE - 1);
  localparam logic [2:0]  BIT_TOP   = 3'(BITS_PER_BYTE - 1);

  state_t     state, state_nxt;
  logic [7:0] shreg;
  logic [7:0] reg_q;
  logic [7:0] data_q;
  logic [2:0] bit_cnt;
  logic [1:0] byte_idx;
  logic       nack;
  logic       sda_low;
  logic       tick;
  logic [1:0] phase;
  logic       accept;
  logic       q_end;

  // busy also covers the done cycle, so a request in that cycle is refused
  assign wr_ready = ~busy;
  assign accept   = wr_valid && wr_ready;
  assign q_end    = tick && (phase == 2'd3);

  // Open-drain data line: only ever pulled low
  assign sda = sda_low ? 1'b0 : 1'bz;

  i2c_qtr_tick #(
    .QTR (QTR)
  ) u_qtr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state != IDLE),
    .clr   (accept),
    .tick  (tick),
    .phase (phase)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and bus line decode from state and bit phase
  always_comb begin
    state_nxt = state;
    scl       = 1'b1;
    sda_low   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = START;
      end
      START: begin
        sda_low = phase[1];
        if (q_end) state_nxt = DATA;
      end
      DATA: begin
        scl     = (phase == 2'd1) || (phase == 2'd2);
        sda_low = ~shreg[7];
        if (q_end && (bit_cnt == 3'd0)) state_nxt = ACK;
      end
      ACK: begin
        scl = (phase == 2'd1) || (phase == 2'd2);
        if (q_end) state_nxt = (nack || (byte_idx == LAST_BYTE)) ? STOP : DATA;
      end
      STOP: begin
        scl     = (phase != 2'd0);
        sda_low = ~phase[1];
        if (q_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, byte shifting, ACK sampling and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= 8'h00;
      reg_q    <= 8'h00;
      data_q   <= 8'h00;
      bit_cnt  <= 3'd0;
      byte_idx <= 2'd0;
      nack     <= 1'b0;
      ack_err  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= (state == STOP) && q_end;
      if (accept) begin
        busy     <= 1'b1;
        ack_err  <= 1'b0;
        shreg    <= {dev_addr, 1'b0};
        reg_q    <= reg_addr;
        data_q   <= wr_data;
        bit_cnt  <= BIT_TOP;
        byte_idx <= 2'd0;
        nack     <= 1'b0;
      end else begin
        if (done) busy <= 1'b0;
        case (state)
          DATA: begin
            // bit_cnt wraps 0 -> 7, ready for the next byte
            if (q_end) begin
              shreg   <= {shreg[6:0], 1'b0};
              bit_cnt <= bit_cnt - 3'd1;
            end
          end
          ACK: begin
            // Sample on the last cycle of the high half of SCL
            if (tick && (phase == 2'd2)) nack <= sda;
            if (q_end) begin
              if (nack) begin
                ack_err <= 1'b1;
              end else if (byte_idx != LAST_BYTE) begin
                byte_idx <= byte_idx + 2'd1;
                shreg    <= (byte_idx == 2'd0) ? reg_q : data_q;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_si5324_i2c_writer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_si5324_i2c_writer
// Description : Directed self-checking bench for si5324_i2c_writer at QTR=4
//               with a bus decoder / ACKing slave model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_si5324_i2c_writer;

  localparam int NO_NACK = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic [6:0] dev_addr = 7'h00;
  logic [7:0] reg_addr = 8'h00;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready, busy, done, ack_err, scl;
  logic       slave_low = 1'b0;
  wire        sda;

  assign sda = slave_low ? 1'b0 : 1'bz;
  pullup (sda);

  si5324_i2c_writer #(
    .CLK_FREQ (400),
    .I2C_FREQ (25)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .dev_addr (dev_addr),
    .reg_addr (reg_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .ack_err  (ack_err),
    .scl      (scl),
    .sda      (sda)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycle numbering: the period after the accept edge is cycle 1
  int cyc = 0;
  int since_done = 1000;
  int acc_cnt = 0;
  int last_gap = 0;

  always @(posedge clk) begin
    if (rst_n && wr_valid && wr_ready) begin
      last_gap = since_done + 1;
      acc_cnt++;
      cyc = 1;
    end else begin
      cyc++;
    end
    if (done) since_done = 1;
    else      since_done++;
  end

  // Bus decoder and slave: logs START/STOP/bytes, ACKs unless told to NACK
  int         nack_byte = NO_NACK;
  int         nbits = 0;
  int         byte_i = 0;
  int         rx_n = 0;
  int         n_start = 0;
  int         n_stop = 0;
  logic [7:0] rx_sr = 8'h00;
  logic [7:0] rx_bytes [0:63];
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;

  always @(negedge clk) begin
    if (!rst_n) begin
      nbits     = 0;
      byte_i    = 0;
      slave_low = 1'b0;
    end else if (scl && prev_scl && (sda != prev_sda)) begin
      if (!sda) begin
        n_start++;
        byte_i = 0;
      end else begin
        n_stop++;
      end
      nbits     = 0;
      slave_low = 1'b0;
    end else if (scl && !prev_scl) begin
      if (nbits < 8) begin
        rx_sr = {rx_sr[6:0], sda};
        nbits++;
        if (nbits == 8) begin
          if (rx_n < 64) rx_bytes[6'(rx_n)] = rx_sr;
          rx_n++;
        end
      end else begin
        nbits++;
      end
    end else if (!scl && prev_scl) begin
      if (nbits == 8) begin
        slave_low = (byte_i != nack_byte);
      end else if (nbits == 9) begin
        slave_low = 1'b0;
        nbits     = 0;
        byte_i++;
      end
    end
    prev_scl = scl;
    prev_sda = sda;
  end

  // One complete request: issue, wait for done, check timing, status and bus
  task automatic do_write(input string tag, input logic [6:0] dev, input logic [7:0] rg,
                          input logic [7:0] dat, input int nk, input int exp_done,
                          input logic exp_err, input int exp_nb, input logic [7:0] exp_b0);
    int b_rx, b_st, b_sp, b_acc, g;
    logic [7:0] exp_b [0:2];
    exp_b[0] = exp_b0;
    exp_b[1] = rg;
    exp_b[2] = dat;
    b_rx  = rx_n;
    b_st  = n_start;
    b_sp  = n_stop;
    b_acc = acc_cnt;
    nack_byte = nk;
    @(negedge clk);
    wr_valid = 1'b1;
    dev_addr = dev;
    reg_addr = rg;
    wr_data  = dat;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (acc_cnt == b_acc && g < 50);
    wr_valid = 1'b0;
    dev_addr = ~dev;
    reg_addr = ~rg;
    wr_data  = ~dat;
    check({tag, "_accept"}, acc_cnt - b_acc, 1);
    check({tag, "_err_clr"}, {31'd0, ack_err}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 1);
    g = 0;
    while (!done && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_done_cyc"}, cyc, exp_done);
    check({tag, "_ack_err"}, {31'd0, ack_err}, {31'd0, exp_err});
    check({tag, "_rdy_at_done"}, {31'd0, wr_ready}, 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, done}, 0);
    check({tag, "_busy_fall"}, {31'd0, busy}, 0);
    check({tag, "_rdy_rise"}, {31'd0, wr_ready}, 1);
    check({tag, "_nbytes"}, rx_n - b_rx, exp_nb);
    check({tag, "_starts"}, n_start - b_st, 1);
    check({tag, "_stops"}, n_stop - b_sp, 1);
    for (int i = 0; i < exp_nb; i++)
      check({tag, "_byte"}, {24'd0, rx_bytes[6'(b_rx + i)]}, {24'd0, exp_b[i]});
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int g, b_rx, b_st, b_sp, b_acc;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (1000) @(negedge clk);
    check("idle_scl", {31'd0, scl}, 1);
    check("idle_sda", {31'd0, sda}, 1);
    check("idle_ready", {31'd0, wr_ready}, 1);
    check("idle_busy", {31'd0, busy}, 0);
    check("idle_done", {31'd0, done}, 0);
    check("idle_ack_err", {31'd0, ack_err}, 0);

    // 116*4+1 = 465 ; (8+36)*4+1 = 177 ; (8+72)*4+1 = 321
    do_write("ok1",   7'h68, 8'h88, 8'h40, NO_NACK, 465, 1'b0, 3, 8'hD0);
    do_write("nack0", 7'h68, 8'h12, 8'h34, 0,       177, 1'b1, 1, 8'hD0);
    do_write("ok2",   7'h2A, 8'hA5, 8'h5A, NO_NACK, 465, 1'b0, 3, 8'h54);
    do_write("nack1", 7'h68, 8'h99, 8'h01, 1,       321, 1'b1, 2, 8'hD0);
    do_write("nack2", 7'h77, 8'h00, 8'hFF, 2,       465, 1'b1, 3, 8'hEE);
    repeat (100) @(negedge clk);
    check("sticky_ack_err", {31'd0, ack_err}, 1);

    // Reset in the middle of B1: cycle 200 is bit 5 of 0x88 (a 0), SCL high
    nack_byte = NO_NACK;
    b_acc = acc_cnt;
    @(negedge clk);
    wr_valid = 1'b1;
    dev_addr = 7'h68;
    reg_addr = 8'h88;
    wr_data  = 8'h40;
    @(negedge clk);
    wr_valid = 1'b0;
    check("rst_accept", acc_cnt - b_acc, 1);
    g = 0;
    while (cyc != 200 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    check("rst_pre_scl", {31'd0, scl}, 1);
    check("rst_pre_sda", {31'd0, sda}, 0);
    rst_n = 1'b0;
    #1;
    check("rst_scl", {31'd0, scl}, 1);
    check("rst_sda", {31'd0, sda}, 1);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_ready", {31'd0, wr_ready}, 1);
    check("rst_ack_err", {31'd0, ack_err}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    do_write("post_rst", 7'h68, 8'h88, 8'h40, NO_NACK, 465, 1'b0, 3, 8'hD0);

    // Back-to-back with wr_valid held high across two transactions
    nack_byte = NO_NACK;
    b_rx  = rx_n;
    b_st  = n_start;
    b_sp  = n_stop;
    b_acc = acc_cnt;
    @(negedge clk);
    wr_valid = 1'b1;
    dev_addr = 7'h10;
    reg_addr = 8'h20;
    wr_data  = 8'h30;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!done && g < 3000);
    check("b2b_done1_cyc", cyc, 465);
    g = 0;
    while (acc_cnt != b_acc + 2 && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("b2b_accepts", acc_cnt - b_acc, 2);
    check("b2b_gap", last_gap, 2);
    g = 0;
    while (!done && g < 3000) begin
      @(negedge clk);
      g++;
    end
    wr_valid = 1'b0;
    check("b2b_done2_cyc", cyc, 465);
    repeat (3) @(negedge clk);
    check("b2b_accept_total", acc_cnt - b_acc, 2);
    check("b2b_starts", n_start - b_st, 2);
    check("b2b_stops", n_stop - b_sp, 2);
    check("b2b_nbytes", rx_n - b_rx, 6);
    check("b2b_b0", {24'd0, rx_bytes[6'(b_rx)]}, 32'h20);
    check("b2b_b5", {24'd0, rx_bytes[6'(b_rx + 5)]}, 32'h30);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
